matrix_feeder: RTL
==================

# matrix_feeder

Upstream staging stage for the matrix multiplier. A host loads two N×N operand matrices (8-bit elements) into internal register files through a simple write port. On a start pulse the block streams both matrices element-by-element in row-major order, one A/B pair per clock with a valid strobe. This is the A/B/en_in sequence the multiplier consumes. A one-cycle done pulse flags the end of each stream.

## Interface
- M, default 2: log2 of matrix dimension.
- N, default 2**M: matrix dimension; derived, not overridden.
- W, default 8: element width.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  element write strobe.
- wr_sel  input  1  0 = write matrix A, 1 = write matrix B.
- wr_addr  input  2*M  row-major element index (row*N + col).
- wr_data  input  W  element value.
- start  input  1  begin streaming; sampled only when idle.
- A_out  output  W  current A element; feeds multiplier A.
- B_out  output  W  current B element; feeds multiplier B.
- en_out  output  1  A_out/B_out valid; feeds multiplier en_in.
- busy  output  1  stream in progress.
- done  output  1  one-cycle pulse after the final element.

## Operation
- Storage: memA and memB, each N*N words of W bits, plus index counter idx of width 2*M+1.
- FSM states:
  - IDLE: wr_en with wr_sel selects memA or memB; memX[wr_addr] <= wr_data. start with wr_en=0 loads element 0 to the outputs, sets idx=1, enters STREAM.
  - STREAM: each edge with idx < N*N loads memA[idx]/memB[idx] to the outputs and increments idx. The edge with idx == N*N clears en_out, A_out and B_out, pulses done and returns to IDLE.
- Order: both matrices stream row-major (index 0 .. N*N-1), identical index for A and B on every valid cycle.
- Writes in STREAM: ignored; memories unchanged. start in STREAM: ignored.
- wr_en and start in the same IDLE cycle: write committed, start ignored, no stream begins. The host must re-assert start.
- A_out/B_out are 0 whenever en_out=0.
- Memories are not cleared at stream end; a second start re-streams the same data.
- Outputs are all registered; no combinational input-to-output path.

## Timing
- Reset (asynchronous, immediate):
  - A_out=0, B_out=0, en_out=0, busy=0, done=0.
  - State IDLE, idx=0.
  - memA and memB all zero.
- start sampled high at edge k (IDLE, wr_en=0):
  - After edge k: en_out=1, busy=1, A_out=memA[0], B_out=memB[0].
  - After edge k+j, for 0 ≤ j ≤ N*N-1: element j presented.
  - After edge k+N*N: en_out=0, busy=0, done=1, outputs 0.
  - After edge k+N*N+1: done=0.
- en_out is high for exactly N*N consecutive cycles; no gaps.
- Latency start→first valid: 1 edge. Earliest restart: start sampled at edge k+N*N+1, giving a 1-cycle gap between streams.
- Reset mid-stream: en_out/busy drop immediately; no done pulse; next start streams zeros.
- Write latency: a write at edge w is visible to a start sampled at edge w+1 or later.

## Test plan
- Basic stream (M=2):
  - Stimulus: reset 2 cycles; load memA[i]=i and memB[i]=15-i for i=0..15; start at edge k.
  - Required: en_out high after edges k..k+15; A_out=0,1,…,15 and B_out=15,14,…,0; done=1 only after edge k+16; busy falls with en_out.
- Start while busy:
  - Stimulus: re-pulse start at edge k+5 of a stream.
  - Required: still exactly 16 valid cycles; single done pulse; no second stream.
- Write while busy:
  - Stimulus: write memA[3]=99 at edge k+2; then start again after done.
  - Required: both streams show A_out=3 at index 3.
- Simultaneous wr_en and start in IDLE:
  - Stimulus: write memB[0]=7 together with start.
  - Required: en_out stays 0. A later start streams B_out=7 first.
- Reset mid-stream:
  - Stimulus: assert reset at cycle 7 of a stream.
  - Required: en_out, busy and A_out go 0 before the next edge; no done pulse. A following start yields 16 cycles of A_out=B_out=0.
- M=1 instance:
  - Stimulus: load memA[i]=i+1 and memB[i]=2*i for i=0..3; start.
  - Required: 4 valid cycles A_out=1,2,3,4 and B_out=0,2,4,6, then done.

Source files
------------

// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder
// Brief    : Holds two NxN operand matrices and streams them row-major,
//            one A/B pair per clock with a valid strobe and an end-of-stream
//            done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_feeder #(
    parameter int M = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic           wr_sel,
    input  logic [2*M-1:0] wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           start,
    output logic [W-1:0]   A_out,
    output logic [W-1:0]   B_out,
    output logic           en_out,
    output logic           busy,
    output logic           done
);
    localparam int N  = 2**M;
    localparam int DEPTH = N * N;
    localparam int IW = 2*M + 1;

    localparam logic [IW-1:0] c_DEPTH    = IW'(DEPTH);
    localparam logic [IW-1:0] c_IDX_ONE  = IW'(1);
    localparam logic [0:0]    c_S_IDLE   = 1'b0;
    localparam logic [0:0]    c_S_STREAM = 1'b1;

    logic [W-1:0]   r_mem_a [DEPTH];
    logic [W-1:0]   r_mem_b [DEPTH];

    logic [0:0]     r_state, w_state_nxt;
    logic [IW-1:0]  r_idx,   w_idx_nxt;
    logic [W-1:0]   r_a,     w_a_nxt;
    logic [W-1:0]   r_b,     w_b_nxt;
    logic           r_en,    w_en_nxt;
    logic           r_busy,  w_busy_nxt;
    logic           r_done,  w_done_nxt;
    logic           w_wr_ok;
    logic [2*M-1:0] w_rd_addr;

    // Host writes only land while idle; a stream always sees a stable matrix.
    assign w_wr_ok   = (r_state == c_S_IDLE) && wr_en;
    assign w_rd_addr = r_idx[2*M-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
        end else if (w_wr_ok) begin
            if (wr_sel) r_mem_b[wr_addr] <= wr_data;
            else        r_mem_a[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                // A write in the same cycle wins; the host must re-issue start.
                if (start && !wr_en) begin
                    w_a_nxt     = r_mem_a[0];
                    w_b_nxt     = r_mem_b[0];
                    w_idx_nxt   = c_IDX_ONE;
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = c_S_STREAM;
                end
            end
            c_S_STREAM: begin
                if (r_idx < c_DEPTH) begin
                    w_a_nxt   = r_mem_a[w_rd_addr];
                    w_b_nxt   = r_mem_b[w_rd_addr];
                    w_idx_nxt = r_idx + c_IDX_ONE;
                end else begin
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_idx_nxt   = '0;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    assign A_out  = r_a;
    assign B_out  = r_b;
    assign en_out = r_en;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire
